// File: rtl/lane_arbiter_pkg.sv
// Shared definitions for the lane arbiter: beat payload type, lane index width helper, lane limit.
package lane_pkg;

    localparam int MAX_LANES   = 16;
    localparam int BEAT_DATA_W = 8;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    function automatic int lane_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lane_arbiter_if.sv
// Single valid/ready lane carrying one payload beat; Source drives, Sink consumes.
interface LaneIntf #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport Source (output valid, output data, input ready);
    modport Sink   (input valid, input data, output ready);
endinterface

// File: rtl/lane_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first asserted req at or after ptr, modulo NUM_LANES.
module rr_pick #(
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned LANE_W    = 2
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    ptr,
    output logic                 gnt_valid,
    output logic [LANE_W-1:0]    gnt_idx
);

    logic [LANE_W:0]   w_sum;
    logic [LANE_W-1:0] w_cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_sum = {1'b0, ptr} + (LANE_W+1)'(i);
            if (w_sum >= (LANE_W+1)'(NUM_LANES)) begin
                w_sum = w_sum - (LANE_W+1)'(NUM_LANES);
            end
            w_cand = w_sum[LANE_W-1:0];
            if (!gnt_valid && req[w_cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/lane_arbiter.sv
// Round-robin N:1 lane collector with a registered valid/ready output tagged by source lane.
// Optional per-lane saturating grant counters on grant_cnt when LANE_ARB_COUNT_EN is defined.
module lane_arbiter
    import lane_pkg::*;
#(
    parameter int  NUM_LANES = 3,
    parameter int  DATA_W    = 8,
    parameter int  CNT_W     = 16,
    localparam int LANE_W    = lane_w(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    LaneIntf.Sink                      lanes [NUM_LANES-1:0],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [LANE_W-1:0]          out_lane
`ifdef LANE_ARB_COUNT_EN
    ,
    output logic [NUM_LANES*CNT_W-1:0] grant_cnt
`endif
);

    if (NUM_LANES < 1 || NUM_LANES > MAX_LANES || CNT_W < 1) begin : g_cfg_check
        $error("lane_arbiter: NUM_LANES must be 1..16 and CNT_W >= 1");
    end

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [LANE_W-1:0]    r_out_lane;
    logic [LANE_W-1:0]    r_rr_ptr;

    logic [NUM_LANES-1:0] w_req;
    logic [NUM_LANES-1:0] w_ready;
    logic [DATA_W-1:0]    w_data [NUM_LANES];
    logic                 w_load;
    logic                 w_gnt_valid;
    logic [LANE_W-1:0]    w_gnt_idx;
    logic                 w_take;

    assign w_load = !r_out_valid || out_ready;
    // Ready is gated by rst_n so no lane can believe it transferred during reset.
    assign w_take = rst_n && w_load && w_gnt_valid;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign w_req[k]       = lanes[k].valid;
        assign w_data[k]      = lanes[k].data;
        assign w_ready[k]     = w_take && (w_gnt_idx == LANE_W'(k));
        assign lanes[k].ready = w_ready[k];
    end

    rr_pick #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_pick (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_out_data <= w_data[w_gnt_idx];
                r_out_lane <= w_gnt_idx;
                r_rr_ptr   <= (w_gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;

`ifdef LANE_ARB_COUNT_EN
    logic [NUM_LANES-1:0] w_xfer;
    logic [CNT_W-1:0]     r_cnt [NUM_LANES];

    assign w_xfer = w_ready & w_req;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (w_xfer[k] && (r_cnt[k] != '1)) begin
                r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
        assign grant_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
    end
`endif

endmodule

// File: tb/tb_lane_arbiter.sv
// Self-checking bench for lane_arbiter (3 lanes, 8-bit data): vector table, corner sequences, random vs. model.
module tb_lane_arbiter;

    localparam int N = 3;

    logic       clk;
    logic       rst_n;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_lane;
`ifdef LANE_ARB_COUNT_EN
    logic [5:0] grant_cnt;
`endif

    logic [2:0] tb_valid;
    logic [7:0] tb_data [N];
    logic [2:0] tb_ready;

    int checks;
    int failures;

    LaneIntf #(.DATA_W(8)) lanes [2:0] ();

    for (genvar k = 0; k < N; k++) begin : g_drv
        assign lanes[k].valid = tb_valid[k];
        assign lanes[k].data  = tb_data[k];
        assign tb_ready[k]    = lanes[k].ready;
    end

    lane_arbiter #(
        .NUM_LANES (3),
        .DATA_W    (8),
        .CNT_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lanes     (lanes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane)
`ifdef LANE_ARB_COUNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] valid;
        logic [7:0] d0, d1, d2;
        logic       ordy;
        logic [2:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_ol;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic r, input logic [2:0] er,
                                input logic eov, input logic [7:0] eod, input logic [1:0] eol);
        vec_t t;
        t.valid = v; t.d0 = a; t.d1 = b; t.d2 = c; t.ordy = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_ol = eol;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic r);
        tb_valid   = v;
        tb_data[0] = a;
        tb_data[1] = b;
        tb_data[2] = c;
        out_ready  = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference arbitration: first valid lane scanning from ptr around the ring.
    function automatic int pick(input logic [2:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    int         m_ptr;
    logic       m_ov;
    logic [7:0] m_od;
    int         m_ol;
    int         m_cnt [N];

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = mk(3'b010, 8'h00, 8'hA5, 8'h00, 1'b1, 3'b010, 1'b1, 8'hA5, 2'd1);
        tbl[1]  = mk(3'b100, 8'h00, 8'h00, 8'h12, 1'b1, 3'b100, 1'b1, 8'h12, 2'd2);
        tbl[2]  = mk(3'b111, 8'h10, 8'h11, 8'h12, 1'b1, 3'b001, 1'b1, 8'h10, 2'd0);
        tbl[3]  = mk(3'b111, 8'h10, 8'h11, 8'h12, 1'b1, 3'b010, 1'b1, 8'h11, 2'd1);
        tbl[4]  = mk(3'b111, 8'h10, 8'h11, 8'h12, 1'b1, 3'b100, 1'b1, 8'h12, 2'd2);
        tbl[5]  = mk(3'b111, 8'h10, 8'h11, 8'h12, 1'b1, 3'b001, 1'b1, 8'h10, 2'd0);
        tbl[6]  = mk(3'b111, 8'h10, 8'h11, 8'h12, 1'b1, 3'b010, 1'b1, 8'h11, 2'd1);
        tbl[7]  = mk(3'b111, 8'h10, 8'h11, 8'h12, 1'b1, 3'b100, 1'b1, 8'h12, 2'd2);
        tbl[8]  = mk(3'b001, 8'h3C, 8'h00, 8'h00, 1'b1, 3'b001, 1'b1, 8'h3C, 2'd0);
        tbl[9]  = mk(3'b111, 8'h55, 8'h66, 8'h77, 1'b0, 3'b000, 1'b1, 8'h3C, 2'd0);
        tbl[10] = mk(3'b111, 8'h55, 8'h66, 8'h77, 1'b0, 3'b000, 1'b1, 8'h3C, 2'd0);
        tbl[11] = mk(3'b111, 8'h55, 8'h66, 8'h77, 1'b0, 3'b000, 1'b1, 8'h3C, 2'd0);
        tbl[12] = mk(3'b111, 8'h55, 8'h66, 8'h77, 1'b0, 3'b000, 1'b1, 8'h3C, 2'd0);
        tbl[13] = mk(3'b100, 8'h00, 8'h00, 8'h9A, 1'b1, 3'b100, 1'b1, 8'h9A, 2'd2);
        tbl[14] = mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h9A, 2'd2);
        tbl[15] = mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h9A, 2'd2);
        tbl[16] = mk(3'b101, 8'hE0, 8'h00, 8'hE2, 1'b1, 3'b001, 1'b1, 8'hE0, 2'd0);
        tbl[17] = mk(3'b101, 8'hE0, 8'h00, 8'hE2, 1'b1, 3'b100, 1'b1, 8'hE2, 2'd2);
        tbl[18] = mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 1'b1, 8'hE2, 2'd2);
        tbl[19] = mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0, 8'hE2, 2'd2);
        tbl[20] = mk(3'b010, 8'h00, 8'h77, 8'h00, 1'b0, 3'b010, 1'b1, 8'h77, 2'd1);
        tbl[21] = mk(3'b111, 8'h01, 8'h02, 8'h03, 1'b0, 3'b000, 1'b1, 8'h77, 2'd1);

        // Reset hold with every lane requesting.
        rst_n = 1'b0;
        drive(3'b111, 8'hAA, 8'hBB, 8'hCC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("reset_ready", 32'(tb_ready), 32'd0);
            cycle();
        end
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_lane", 32'(out_lane), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].valid, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].ordy);
            #1 chk($sformatf("vec%0d_ready", i), 32'(tb_ready), 32'(tbl[i].exp_rdy));
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp_od));
            chk($sformatf("vec%0d_lane", i), 32'(out_lane), 32'(tbl[i].exp_ol));
        end

        // Reset while a beat is held: beat discarded, pointer returns to lane 0.
        rst_n = 1'b0;
        drive(3'b111, 8'h21, 8'h22, 8'h23, 1'b0);
        #1 chk("midrst_ready", 32'(tb_ready), 32'd0);
        cycle();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        drive(3'b111, 8'h21, 8'h22, 8'h23, 1'b1);
        #1 chk("postrst_ready", 32'(tb_ready), 32'b001);
        cycle();
        chk("postrst_data", 32'(out_data), 32'h21);
        chk("postrst_lane", 32'(out_lane), 32'd0);

`ifdef LANE_ARB_COUNT_EN
        rst_n = 1'b0;
        drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        cycle();
        chk("cnt_reset", 32'(grant_cnt), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(3'b001, 8'(i), 8'h00, 8'h00, 1'b1);
            cycle();
            if (i == 1) chk("cnt_two", 32'(grant_cnt), 32'h2);
        end
        chk("cnt_sat", 32'(grant_cnt), 32'h3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("cnt_clear", 32'(grant_cnt), 32'd0);
`endif

        // Randomised traffic against the reference model.
        m_ptr = 0; m_ov = 1'b0; m_od = '0; m_ol = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        for (int c = 0; c < 400; c++) begin
            int  g;
            bit  load;
            logic [2:0] erdy;
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
            drive(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            #1;
            g    = pick(tb_valid, m_ptr);
            load = !m_ov || out_ready;
            erdy = (rst_n && load && g >= 0) ? 3'(1 << g) : 3'b000;
            chk("rnd_ready", 32'(tb_ready), 32'(erdy));
            if (!rst_n) begin
                m_ptr = 0; m_ov = 1'b0; m_od = '0; m_ol = 0;
                for (int k = 0; k < N; k++) m_cnt[k] = 0;
            end else if (load) begin
                m_ov = (g >= 0);
                if (g >= 0) begin
                    m_od  = tb_data[g];
                    m_ol  = g;
                    m_ptr = (g + 1) % N;
                    if (m_cnt[g] < 3) m_cnt[g]++;
                end
            end
            cycle();
            chk("rnd_valid", 32'(out_valid), 32'(m_ov));
            chk("rnd_data", 32'(out_data), 32'(m_od));
            chk("rnd_lane", 32'(out_lane), 32'(m_ol));
`ifdef LANE_ARB_COUNT_EN
            chk("rnd_cnt", 32'(grant_cnt), 32'((m_cnt[2] << 4) | (m_cnt[1] << 2) | m_cnt[0]));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
